fetch_line_ctrl: RTL and testbench

- Sits between the FTQ fetch port and the ICache; downstream it feeds preDecode.
- Accepts one fetch block (start address, size, prediction) from the FTQ and issues one or two line reads to the ICache, one at a time.
- Aligns the returned bytes to the block start and presents the block to preDecode with a valid/ready handshake.
- Handles squash/falsepred flushes, including draining ICache responses that are already in flight.

---
 rtl/fetch_line_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_line_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_ctrl.sv
// Fetch-block line reader: takes one FTQ block, reads one or two ICache lines,
// aligns the bytes to the block start and hands the block to preDecode.
module fetch_line_ctrl #(
    parameter int XLEN          = 64,
    parameter int FTQ_IDX_W     = 5,
    parameter int LINE_BYTES    = 64,
    parameter int MAX_BLK_BYTES = 32,
    parameter int SIZE_W        = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_fetch_req,
    output logic                       o_fetch_rdy,
    input  logic [FTQ_IDX_W-1:0]       i_fetch_ftqIdx,
    input  logic [XLEN-1:0]            i_fetch_startAddr,
    input  logic [SIZE_W-1:0]          i_fetch_size,
    input  logic                       i_fetch_taken,
    input  logic [XLEN-1:0]            i_fetch_nextAddr,
    output logic                       o_ic_req,
    output logic [XLEN-1:0]            o_ic_addr,
    input  logic                       i_ic_rdy,
    input  logic                       i_ic_resp_vld,
    input  logic [LINE_BYTES*8-1:0]    i_ic_resp_data,
    output logic                       o_blk_vld,
    input  logic                       i_blk_rdy,
    output logic [FTQ_IDX_W-1:0]       o_blk_ftqIdx,
    output logic [XLEN-1:0]            o_blk_startAddr,
    output logic [SIZE_W-1:0]          o_blk_size,
    output logic                       o_blk_taken,
    output logic [XLEN-1:0]            o_blk_nextAddr,
    output logic [MAX_BLK_BYTES*8-1:0] o_blk_data
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int SUM_W = ((SIZE_W > OFF_W) ? SIZE_W : OFF_W) + 1;

    typedef enum logic [2:0] {
        IDLE, REQ0, WAIT0, REQ1, WAIT1, OUT, DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [FTQ_IDX_W-1:0]    ftq_idx_reg;
    logic [XLEN-1:0]         start_addr_reg;
    logic [SIZE_W-1:0]       size_reg;
    logic                    taken_reg;
    logic [XLEN-1:0]         next_addr_reg;
    logic                    cross_reg;
    logic [LINE_BYTES*8-1:0] buf0_reg, buf1_reg;

    logic                    accept;
    logic                    cross_next;
    logic [XLEN-1:0]         line0, line1;
    logic [OFF_W-1:0]        off;
    logic [2*LINE_BYTES*8-1:0] shifted;

    assign off   = start_addr_reg[OFF_W-1:0];
    assign line0 = {start_addr_reg[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign line1 = line0 + XLEN'(LINE_BYTES);

    assign cross_next = (SUM_W'(i_fetch_startAddr[OFF_W-1:0]) + SUM_W'(i_fetch_size))
                        > SUM_W'(LINE_BYTES);

    always_comb begin
        state_next  = state_reg;
        o_fetch_rdy = 1'b0;
        o_ic_req    = 1'b0;
        o_ic_addr   = '0;
        o_blk_vld   = 1'b0;
        accept      = 1'b0;

        o_fetch_rdy = !i_flush && (state_reg == IDLE || (state_reg == OUT && i_blk_rdy));
        accept      = i_fetch_req && o_fetch_rdy;

        case (state_reg)
            IDLE: begin
                if (accept) state_next = REQ0;
            end
            REQ0: begin
                o_ic_req  = !i_flush;
                o_ic_addr = line0;
                if (i_flush)       state_next = IDLE;
                else if (i_ic_rdy) state_next = WAIT0;
            end
            WAIT0: begin
                // A flush with no response yet must wait out the in-flight read.
                if (i_ic_resp_vld) state_next = i_flush ? IDLE : (cross_reg ? REQ1 : OUT);
                else if (i_flush)  state_next = DRAIN;
            end
            REQ1: begin
                o_ic_req  = !i_flush;
                o_ic_addr = line1;
                if (i_flush)       state_next = IDLE;
                else if (i_ic_rdy) state_next = WAIT1;
            end
            WAIT1: begin
                if (i_ic_resp_vld) state_next = i_flush ? IDLE : OUT;
                else if (i_flush)  state_next = DRAIN;
            end
            OUT: begin
                o_blk_vld = !i_flush;
                if (i_flush)        state_next = IDLE;
                else if (i_blk_rdy) state_next = accept ? REQ0 : IDLE;
            end
            DRAIN: begin
                if (i_ic_resp_vld) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ftq_idx_reg    <= '0;
            start_addr_reg <= '0;
            size_reg       <= '0;
            taken_reg      <= 1'b0;
            next_addr_reg  <= '0;
            cross_reg      <= 1'b0;
            buf0_reg       <= '0;
            buf1_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                ftq_idx_reg    <= i_fetch_ftqIdx;
                start_addr_reg <= i_fetch_startAddr;
                size_reg       <= i_fetch_size;
                taken_reg      <= i_fetch_taken;
                next_addr_reg  <= i_fetch_nextAddr;
                cross_reg      <= cross_next;
            end
            if (state_reg == WAIT0 && i_ic_resp_vld && !i_flush) buf0_reg <= i_ic_resp_data;
            if (state_reg == WAIT1 && i_ic_resp_vld && !i_flush) buf1_reg <= i_ic_resp_data;
        end
    end

    assign o_blk_ftqIdx    = ftq_idx_reg;
    assign o_blk_startAddr = start_addr_reg;
    assign o_blk_size      = size_reg;
    assign o_blk_taken     = taken_reg;
    assign o_blk_nextAddr  = next_addr_reg;

    // Without a line crossing, every byte below size comes from buf0, so stale buf1 is harmless.
    assign shifted = {buf1_reg, buf0_reg} >> {off, 3'b000};

    generate
        for (genvar gi = 0; gi < MAX_BLK_BYTES; gi++) begin : g_blk_byte
            assign o_blk_data[gi*8 +: 8] = (size_reg > SIZE_W'(gi)) ? shifted[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always @(posedge clk) begin
        if (!rst) begin
            if (accept)
                assert (i_fetch_size != '0 && i_fetch_size <= SIZE_W'(MAX_BLK_BYTES));
            if (state_reg == IDLE || state_reg == REQ0 || state_reg == REQ1 || state_reg == OUT)
                assert (!i_ic_resp_vld);
        end
    end

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Directed bench for fetch_line_ctrl: single/cross/short blocks, flushes,
// backpressure with back-to-back accept, and reset mid-request.
module tb_fetch_line_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_flush;
    logic         i_fetch_req;
    logic         o_fetch_rdy;
    logic [4:0]   i_fetch_ftqIdx;
    logic [63:0]  i_fetch_startAddr;
    logic [6:0]   i_fetch_size;
    logic         i_fetch_taken;
    logic [63:0]  i_fetch_nextAddr;
    logic         o_ic_req;
    logic [63:0]  o_ic_addr;
    logic         i_ic_rdy;
    logic         i_ic_resp_vld;
    logic [511:0] i_ic_resp_data;
    logic         o_blk_vld;
    logic         i_blk_rdy;
    logic [4:0]   o_blk_ftqIdx;
    logic [63:0]  o_blk_startAddr;
    logic [6:0]   o_blk_size;
    logic         o_blk_taken;
    logic [63:0]  o_blk_nextAddr;
    logic [255:0] o_blk_data;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_line_ctrl dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_fetch_req(i_fetch_req), .o_fetch_rdy(o_fetch_rdy),
        .i_fetch_ftqIdx(i_fetch_ftqIdx), .i_fetch_startAddr(i_fetch_startAddr),
        .i_fetch_size(i_fetch_size), .i_fetch_taken(i_fetch_taken),
        .i_fetch_nextAddr(i_fetch_nextAddr),
        .o_ic_req(o_ic_req), .o_ic_addr(o_ic_addr), .i_ic_rdy(i_ic_rdy),
        .i_ic_resp_vld(i_ic_resp_vld), .i_ic_resp_data(i_ic_resp_data),
        .o_blk_vld(o_blk_vld), .i_blk_rdy(i_blk_rdy),
        .o_blk_ftqIdx(o_blk_ftqIdx), .o_blk_startAddr(o_blk_startAddr),
        .o_blk_size(o_blk_size), .o_blk_taken(o_blk_taken),
        .o_blk_nextAddr(o_blk_nextAddr), .o_blk_data(o_blk_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Line whose byte j holds base+j.
    function automatic logic [511:0] mk_line(input logic [7:0] base);
        logic [511:0] l;
        l = '0;
        for (int j = 0; j < 64; j++) l[j*8 +: 8] = base + 8'(j);
        return l;
    endfunction

    // First n bytes hold first, first+1, ...; the rest are zero.
    function automatic logic [255:0] ramp(input logic [7:0] first, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = first + 8'(i);
        return r;
    endfunction

    task automatic start_fetch(input logic [4:0] idx, input logic [63:0] addr, input logic [6:0] sz,
                               input logic tk, input logic [63:0] nxt);
        i_fetch_req       = 1'b1;
        i_fetch_ftqIdx    = idx;
        i_fetch_startAddr = addr;
        i_fetch_size      = sz;
        i_fetch_taken     = tk;
        i_fetch_nextAddr  = nxt;
    endtask

    logic [255:0] exp_data;

    initial begin
        rst = 1'b1; i_flush = 0; i_fetch_req = 0; i_fetch_ftqIdx = 0; i_fetch_startAddr = 0;
        i_fetch_size = 0; i_fetch_taken = 0; i_fetch_nextAddr = 0; i_ic_rdy = 1;
        i_ic_resp_vld = 0; i_ic_resp_data = 0; i_blk_rdy = 0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_fetch_rdy", 256'(o_fetch_rdy), 256'd1);
        chk("rst_ic_req",    256'(o_ic_req), 256'd0);
        chk("rst_blk_vld",   256'(o_blk_vld), 256'd0);
        chk("rst_blk_data",  o_blk_data, 256'd0);
        chk("rst_blk_start", 256'(o_blk_startAddr), 256'd0);

        // Single line block
        start_fetch(5'd3, 64'h1000, 7'd32, 1'b1, 64'h2000); #1;
        chk("t1_accept_rdy", 256'(o_fetch_rdy), 256'd1);
        tick(); i_fetch_req = 0; #1;
        chk("t1_ic_req", 256'(o_ic_req), 256'd1);
        chk("t1_ic_addr", 256'(o_ic_addr), 256'h1000);
        tick();
        chk("t1_wait_noreq", 256'(o_ic_req), 256'd0);
        chk("t1_wait_novld", 256'(o_blk_vld), 256'd0);
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h00);
        tick(); i_ic_resp_vld = 0; #1;
        chk("t1_blk_vld", 256'(o_blk_vld), 256'd1);
        chk("t1_blk_data", o_blk_data, ramp(8'h00, 32));
        chk("t1_ftqIdx", 256'(o_blk_ftqIdx), 256'd3);
        chk("t1_size", 256'(o_blk_size), 256'd32);
        chk("t1_taken", 256'(o_blk_taken), 256'd1);
        chk("t1_nextAddr", 256'(o_blk_nextAddr), 256'h2000);
        chk("t1_rdy_bp", 256'(o_fetch_rdy), 256'd0);
        i_blk_rdy = 1; #1;
        chk("t1_rdy_hs", 256'(o_fetch_rdy), 256'd1);
        tick(); i_blk_rdy = 0; #1;
        chk("t1_idle_vld", 256'(o_blk_vld), 256'd0);

        // Cross-line block, with one stalled cycle on the second request
        start_fetch(5'd4, 64'h1030, 7'd32, 1'b0, 64'h1050);
        tick(); i_fetch_req = 0; #1;
        chk("t2_ic_addr0", 256'(o_ic_addr), 256'h1000);
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h00);
        tick(); i_ic_resp_vld = 0; i_ic_rdy = 0; #1;
        chk("t2_ic_req1", 256'(o_ic_req), 256'd1);
        chk("t2_ic_addr1", 256'(o_ic_addr), 256'h1040);
        tick(); i_ic_rdy = 1; #1;
        chk("t2_stall_req", 256'(o_ic_req), 256'd1);
        chk("t2_stall_addr", 256'(o_ic_addr), 256'h1040);
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h80);
        tick(); i_ic_resp_vld = 0; #1;
        exp_data = ramp(8'h30, 16) | (ramp(8'h80, 16) << 128);
        chk("t2_blk_vld", 256'(o_blk_vld), 256'd1);
        chk("t2_blk_data", o_blk_data, exp_data);
        i_blk_rdy = 1;
        tick(); i_blk_rdy = 0;

        // Short block: bytes past size read as zero
        start_fetch(5'd5, 64'h2004, 7'd12, 1'b0, 64'h2010);
        tick(); i_fetch_req = 0; #1;
        chk("t3_ic_addr", 256'(o_ic_addr), 256'h2000);
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h40);
        tick(); i_ic_resp_vld = 0; #1;
        chk("t3_blk_vld", 256'(o_blk_vld), 256'd1);
        chk("t3_blk_data", o_blk_data, ramp(8'h44, 12));
        i_blk_rdy = 1;
        tick(); i_blk_rdy = 0;

        // Flush in WAIT0, response three cycles later is drained
        start_fetch(5'd6, 64'h1000, 7'd8, 1'b0, 64'h1008);
        tick(); i_fetch_req = 0;
        tick();
        i_flush = 1; #1;
        chk("t4_flush_rdy", 256'(o_fetch_rdy), 256'd0);
        tick(); i_flush = 0; #1;
        chk("t4_drain_rdy", 256'(o_fetch_rdy), 256'd0);
        chk("t4_drain_req", 256'(o_ic_req), 256'd0);
        tick();
        chk("t4_drain_rdy2", 256'(o_fetch_rdy), 256'd0);
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'hA0); #1;
        chk("t4_drain_rdy3", 256'(o_fetch_rdy), 256'd0);
        chk("t4_drain_vld", 256'(o_blk_vld), 256'd0);
        tick(); i_ic_resp_vld = 0; #1;
        chk("t4_idle_rdy", 256'(o_fetch_rdy), 256'd1);
        chk("t4_idle_vld", 256'(o_blk_vld), 256'd0);

        // Flush coincident with the WAIT1 response
        start_fetch(5'd7, 64'h1030, 7'd32, 1'b0, 64'h1050);
        tick(); i_fetch_req = 0;
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h00);
        tick(); i_ic_resp_vld = 0;
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h80); i_flush = 1;
        tick(); i_ic_resp_vld = 0; i_flush = 0; #1;
        chk("t5_idle_rdy", 256'(o_fetch_rdy), 256'd1);
        chk("t5_idle_vld", 256'(o_blk_vld), 256'd0);
        chk("t5_idle_req", 256'(o_ic_req), 256'd0);

        // Backpressure, then handshake together with a new accept
        start_fetch(5'd8, 64'h1000, 7'd32, 1'b1, 64'h1020);
        tick(); i_fetch_req = 0;
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h10);
        tick(); i_ic_resp_vld = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t6_stall_vld", 256'(o_blk_vld), 256'd1);
            chk("t6_stall_data", o_blk_data, ramp(8'h10, 32));
            tick();
        end
        i_blk_rdy = 1;
        start_fetch(5'd9, 64'h3000, 7'd16, 1'b0, 64'h3010); #1;
        chk("t6_b2b_rdy", 256'(o_fetch_rdy), 256'd1);
        chk("t6_b2b_vld", 256'(o_blk_vld), 256'd1);
        tick(); i_blk_rdy = 0; i_fetch_req = 0; #1;
        chk("t6_new_req", 256'(o_ic_req), 256'd1);
        chk("t6_new_addr", 256'(o_ic_addr), 256'h3000);
        chk("t6_new_vld", 256'(o_blk_vld), 256'd0);
        chk("t6_new_idx", 256'(o_blk_ftqIdx), 256'd9);
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'hC0);
        tick(); i_ic_resp_vld = 0; #1;
        chk("t6_new_data", o_blk_data, ramp(8'hC0, 16));
        i_blk_rdy = 1;
        tick(); i_blk_rdy = 0;

        // Reset while the second line request is pending
        start_fetch(5'd10, 64'h1030, 7'd32, 1'b0, 64'h1050);
        tick(); i_fetch_req = 0;
        tick();
        i_ic_resp_vld = 1; i_ic_resp_data = mk_line(8'h00);
        tick(); i_ic_resp_vld = 0; #1;
        chk("t7_req1", 256'(o_ic_req), 256'd1);
        rst = 1;
        tick(); rst = 0; #1;
        chk("t7_rst_req", 256'(o_ic_req), 256'd0);
        chk("t7_rst_vld", 256'(o_blk_vld), 256'd0);
        chk("t7_rst_rdy", 256'(o_fetch_rdy), 256'd1);
        chk("t7_rst_start", 256'(o_blk_startAddr), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
